// File: rtl/semiring_pkg.sv
// Semiring operators plus mode and FSM encodings shared by the FIR array.
// Operators work on a MAX_W container; callers pass the live lane width.
package semiring_pkg;

   localparam int unsigned MAX_W  = 8;
   localparam int unsigned PROD_W = 2 * MAX_W;

   typedef logic [MAX_W-1:0]  word_t;
   typedef logic [PROD_W-1:0] prod_t;

   typedef enum logic [1:0] {
      MODE_SHIFT = 2'b00,
      MODE_MOD   = 2'b01,
      MODE_SAT   = 2'b10,
      MODE_TROP  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_RUN   = 2'b10,
      ST_FLUSH = 2'b11
   } state_e;

   function automatic prod_t sr_mask(input int unsigned width);
      return (prod_t'(1) << width) - prod_t'(1);
   endfunction

   function automatic word_t sr_clamp(input prod_t v, input int unsigned width);
      prod_t m;
      m = sr_mask(width);
      return word_t'((v > m) ? m : v);
   endfunction

   // Operands are zero-extended lane words, so the 2W product never overflows.
   function automatic word_t sr_mul(input mode_e mode, input word_t a, input word_t b,
                                    input int unsigned width);
      prod_t prod;
      word_t res;
      prod = prod_t'(a) * prod_t'(b);
      case (mode)
         MODE_MOD:  res = word_t'(prod & sr_mask(width));
         MODE_SAT:  res = sr_clamp(prod, width);
         MODE_TROP: res = sr_clamp(prod_t'(a) + prod_t'(b), width);
         default:   res = b;
      endcase
      return res;
   endfunction

   function automatic word_t sr_add(input mode_e mode, input word_t a, input word_t b,
                                    input int unsigned width);
      prod_t sum;
      word_t res;
      sum = prod_t'(a) + prod_t'(b);
      case (mode)
         MODE_MOD:  res = word_t'(sum & sr_mask(width));
         MODE_SAT:  res = sr_clamp(sum, width);
         MODE_TROP: res = (a < b) ? a : b;
         default:   res = a;
      endcase
      return res;
   endfunction

   function automatic word_t sr_identity(input mode_e mode, input int unsigned width);
      return (mode == MODE_TROP) ? word_t'(sr_mask(width)) : word_t'(0);
   endfunction

endpackage

// File: rtl/semiring_fir_array_if.sv
// Streaming data bus of the semiring FIR array: sample/weight input and lane results.
interface semiring_fir_array_if #(
   parameter int unsigned IO_BITS = 8
);
   logic [IO_BITS-1:0] din;
   logic               din_valid;
   logic               din_ready;
   logic [IO_BITS-1:0] dout;
   logic               dout_valid;

   modport master (output din, din_valid, input din_ready, dout, dout_valid);
   modport slave  (input din, din_valid, output din_ready, dout, dout_valid);
endinterface

// File: rtl/semiring_pe.sv
// One lane-stage of the transposed FIR: weight register plus partial-result register.
module semiring_pe
   import semiring_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  mode_e            mode,
   input  logic             advance,
   input  logic             load,
   input  logic             clear_seed,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] p_next,
   input  logic [WIDTH-1:0] w_next,
   output logic [WIDTH-1:0] w,
   output logic [WIDTH-1:0] p
);

   logic [WIDTH-1:0] p_term;
   logic [WIDTH-1:0] p_new;

   // A fresh run replaces the downstream partial with the semiring identity.
   always_comb begin
      p_term = clear_seed ? WIDTH'(sr_identity(mode, WIDTH)) : p_next;
      if (mode == MODE_SHIFT) begin
         p_new = p_term;
      end else begin
         p_new = WIDTH'(sr_add(mode, MAX_W'(p_term),
                               sr_mul(mode, MAX_W'(w), MAX_W'(x), WIDTH), WIDTH));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w <= '0;
         p <= '0;
      end else begin
         if (load)    w <= w_next;
         if (advance) p <= p_new;
      end
   end

endmodule

// File: rtl/semiring_fir_array.sv
// Multi-lane systolic semiring FIR: control FSM, counters and lane packing around
// a LANES x STAGES grid of processing elements.
module semiring_fir_array
   import semiring_pkg::*;
#(
   parameter int unsigned IO_BITS = 8,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned STAGES  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           mode,
   input  logic                 load_start,
   input  logic                 flush_start,
   output logic                 load_done,
   output logic                 busy,
   semiring_fir_array_if.slave  bus
);

   localparam int unsigned LANES = IO_BITS / WIDTH;
   localparam int unsigned CNT_W = $clog2(STAGES);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mode_e            mode_q, mode_d;
   logic             dout_valid_q, dout_valid_d;
   logic             load_done_q, load_done_d;
   logic             busy_q, din_ready_q;
   logic             adv, ld, seed, inject;
   logic [WIDTH-1:0] id_lane;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         mode_q       <= MODE_SHIFT;
         dout_valid_q <= 1'b0;
         load_done_q  <= 1'b0;
         busy_q       <= 1'b0;
         din_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mode_q       <= mode_d;
         dout_valid_q <= dout_valid_d;
         load_done_q  <= load_done_d;
         busy_q       <= (state_d != ST_IDLE);
         din_ready_q  <= (state_d != ST_FLUSH);
      end
   end

   // The run-start sample already uses the incoming mode, hence mode_d drives the PEs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mode_d       = mode_q;
      dout_valid_d = 1'b0;
      load_done_d  = 1'b0;
      adv          = 1'b0;
      ld           = 1'b0;
      seed         = 1'b0;
      inject       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end else if (bus.din_valid) begin
               state_d      = ST_RUN;
               mode_d       = mode_e'(mode);
               adv          = 1'b1;
               seed         = 1'b1;
               dout_valid_d = 1'b1;
            end
         end
         ST_LOAD: begin
            if (bus.din_valid) begin
               ld = 1'b1;
               if (cnt_q == CNT_W'(STAGES - 1)) begin
                  state_d     = ST_IDLE;
                  cnt_d       = '0;
                  load_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_RUN: begin
            if (bus.din_valid) begin
               adv          = 1'b1;
               dout_valid_d = 1'b1;
            end
            if (flush_start) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end
         end
         ST_FLUSH: begin
            adv          = 1'b1;
            inject       = 1'b1;
            dout_valid_d = 1'b1;
            if (cnt_q == CNT_W'(STAGES - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign id_lane        = WIDTH'(sr_identity(mode_d, WIDTH));
   assign bus.dout_valid = dout_valid_q;
   assign bus.din_ready  = din_ready_q;
   assign load_done      = load_done_q;
   assign busy           = busy_q;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [WIDTH-1:0] x_lane;
      logic [WIDTH-1:0] w_q [STAGES];
      logic [WIDTH-1:0] p_q [STAGES];

      assign x_lane = inject ? id_lane : bus.din[l*WIDTH +: WIDTH];
      assign bus.dout[l*WIDTH +: WIDTH] = p_q[0];

      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         logic [WIDTH-1:0] p_nxt;
         logic [WIDTH-1:0] w_nxt;
         logic             seed_k;

         // Tail stage: identity (or raw sample when shifting) stands in for p[S].
         if (k == STAGES - 1) begin : g_tail
            assign p_nxt  = (mode_d == MODE_SHIFT) ? x_lane : id_lane;
            assign w_nxt  = bus.din[l*WIDTH +: WIDTH];
            assign seed_k = 1'b0;
         end else begin : g_body
            assign p_nxt  = p_q[k+1];
            assign w_nxt  = w_q[k+1];
            assign seed_k = seed;
         end

         semiring_pe #(.WIDTH(WIDTH)) u_pe (
            .clk        (clk),
            .rst_n      (rst_n),
            .mode       (mode_d),
            .advance    (adv),
            .load       (ld),
            .clear_seed (seed_k),
            .x          (x_lane),
            .p_next     (p_nxt),
            .w_next     (w_nxt),
            .w          (w_q[k]),
            .p          (p_q[k])
         );
      end
   end

endmodule
